// File: rtl/ssd_scan_pkg.sv
// Shared seven-segment display constants and types.
// Other display blocks import this package, so the segment patterns and
// digit-enable codes are defined only here.
// Patterns are {a,b,c,d,e,f,g,dp}, active-low. Digit enables are
// active-low and one-cold, with bit0 as the rightmost digit.
package ssd_scan_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DP    = 8'hFE;  // decimal point only

  // Entry i holds the pattern for digit i.
  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'h09, 8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  // Entry i holds the enable code for display position i.
  localparam logic [3:0][3:0] DIG_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]      DIG_OFF = 4'b1111;

  // Any code above 9 decodes to blank.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDX_UNITS = 2'd0,
    IDX_TENS  = 2'd1,
    IDX_SPARE = 2'd2,
    IDX_WRAP  = 2'd3
  } dig_idx_e;

endpackage

// File: rtl/ssd_scan_if.sv
// Bundle between the upstream counter and the display scanner.
// The mst modport drives value/value_vld.
// The slv modport (ssd_scan) drives ssd_ctl/segs.
interface ssd_scan_if;
  logic [3:0] value;      // binary count 0..15
  logic       value_vld;  // sample strobe
  logic [3:0] ssd_ctl;    // digit enables, active-low one-cold
  logic [7:0] segs;       // segment pattern, active-low

  modport mst (output value, value_vld, input  ssd_ctl, segs);
  modport slv (input  value, value_vld, output ssd_ctl, segs);
endinterface

// File: rtl/ssd_decoder.sv
// Combinational binary-to-seven-segment decoder.
//   digit_i : 4-bit digit; any code above 9 produces blank
//   segs_o  : {a,b,c,d,e,f,g,dp} active-low, with dp always off
module ssd_decoder
  import ssd_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] segs_o
);

  always_comb begin
    segs_o = SEG_BLANK;
    for (int i = 0; i < 10; i++)
      if (digit_i == 4'(i)) segs_o = SEG_DIGIT[i];
  end

endmodule

// File: rtl/ssd_scan.sv
// Scanner for a four-digit seven-segment display showing a 0..15 count.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : ssd_scan_if.slv, carrying value/value_vld in and ssd_ctl/segs out
// Digit 0 shows the units, digit 1 shows the tens (blank below 10), and
// digit 2 is always blank. Digit 3 shows a lone decimal point once the
// upstream counter has been seen wrapping 15 -> 0. The top two bits of a
// free-running refresh counter select the digit. Outputs are registered,
// so they show the digit selected one clock earlier.
module ssd_scan
  import ssd_scan_pkg::*;
#(
  parameter int DIV_W = 17  // legal range 3..24
) (
  input  logic       clk,
  input  logic       rst,
  ssd_scan_if.slv    bus
);

  logic [3:0]       held_q, held_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [3:0]       ctl_q,  ctl_d;
  logic [7:0]       segs_q, segs_d;

  dig_idx_e   idx;
  logic [3:0] units, dec_digit;
  logic [7:0] dec_segs;

  assign idx = dig_idx_e'(cnt_q[DIV_W-1 -: 2]);

  always_comb begin
    held_d = bus.value_vld ? bus.value : held_q;
    // Count 15 followed by a 0 sample means the upstream counter wrapped.
    // A 15 held across repeated samples does not match this condition.
    wrap_d = wrap_q | (bus.value_vld && bus.value == 4'd0 && held_q == 4'd15);
    cnt_d  = cnt_q + 1'b1;
  end

  assign units = (held_q >= 4'd10) ? held_q - 4'd10 : held_q;

  // A single decoder is shared by the units and tens positions.
  always_comb begin
    dec_digit = DIGIT_BLANK;
    case (idx)
      IDX_UNITS: dec_digit = units;
      IDX_TENS:  dec_digit = (held_q >= 4'd10) ? 4'd1 : DIGIT_BLANK;
      default:   dec_digit = DIGIT_BLANK;
    endcase
  end

  ssd_decoder u_dec (
    .digit_i (dec_digit),
    .segs_o  (dec_segs)
  );

  always_comb begin
    ctl_d  = DIG_EN[idx];
    segs_d = dec_segs;
    if (idx == IDX_WRAP) segs_d = wrap_q ? SEG_DP : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
      ctl_q  <= DIG_OFF;
      segs_q <= SEG_BLANK;
    end else begin
      held_q <= held_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
      ctl_q  <= ctl_d;
      segs_q <= segs_d;
    end
  end

  assign bus.ssd_ctl = ctl_q;
  assign bus.segs    = segs_q;

endmodule
